// File: rtl/ahbl_pkg.sv
// Shared AHB-lite encodings and small helpers for the command master.
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  // Sizes above a word are not supported on a 32-bit bus; fold them to word.
  function automatic logic [2:0] norm_size(input logic [2:0] s);
    return (s > HSIZE_WORD) ? HSIZE_WORD : s;
  endfunction

endpackage

// File: rtl/ahbl_lane_align.sv
// Byte-lane steering: write replication onto HWDATA, read extraction from HRDATA.
module ahbl_lane_align
  import ahbl_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] hrdata,
  output logic [31:0] hwdata,
  output logic [31:0] rdata
);

  logic [31:0] rd_sh;

  always_comb begin
    rd_sh = hrdata >> {lane, 3'b000};
    case (size)
      HSIZE_BYTE: begin
        hwdata = {4{wdata[7:0]}};
        rdata  = {24'h0, rd_sh[7:0]};
      end
      HSIZE_HALF: begin
        hwdata = {2{wdata[15:0]}};
        rdata  = {16'h0, rd_sh[15:0]};
      end
      default: begin
        hwdata = wdata;
        rdata  = hrdata;
      end
    endcase
  end

endmodule

// File: rtl/ahbl_cmd_master.sv
// AHB-lite initiator: valid/ready commands become single NONSEQ transfers with
// pipelined address and data phases, responses returned in order.
module ahbl_cmd_master
  import ahbl_pkg::*;
#(
  parameter int ADDR_W = 32
)
(
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [2:0]        cmd_size,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [31:0]       HWDATA,
  input  logic              HREADY,
  input  logic [31:0]       HRDATA,
  input  logic              HRESP
);

  logic              ap_vld_q, ap_vld_d;
  logic [ADDR_W-1:0] ap_addr_q, ap_addr_d;
  logic              ap_write_q, ap_write_d;
  logic [2:0]        ap_size_q, ap_size_d;
  logic [31:0]       ap_wdata_q, ap_wdata_d;

  logic              dp_vld_q, dp_vld_d;
  logic              dp_write_q, dp_write_d;
  logic [2:0]        dp_size_q, dp_size_d;
  logic [1:0]        dp_lane_q, dp_lane_d;
  logic [31:0]       dp_wdata_q, dp_wdata_d;

  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;

  logic [2:0]        cmd_size_n;
  logic [ADDR_W-1:0] cmd_addr_a;
  logic [31:0]       rd_lane;

  // An empty address slot may fill even while HREADY is low (IDLE->NONSEQ
  // is legal mid-wait); a pending NONSEQ only advances when HREADY is high.
  assign cmd_ready = ~ap_vld_q | HREADY;

  always_comb begin
    cmd_size_n = norm_size(cmd_size);
    cmd_addr_a = cmd_addr;
    if (cmd_size_n == HSIZE_HALF) cmd_addr_a[0]   = 1'b0;
    if (cmd_size_n == HSIZE_WORD) cmd_addr_a[1:0] = 2'b00;

    ap_vld_d   = ap_vld_q;
    ap_addr_d  = ap_addr_q;
    ap_write_d = ap_write_q;
    ap_size_d  = ap_size_q;
    ap_wdata_d = ap_wdata_q;
    if (cmd_ready) begin
      ap_vld_d = cmd_valid;
      if (cmd_valid) begin
        ap_addr_d  = cmd_addr_a;
        ap_write_d = cmd_write;
        ap_size_d  = cmd_size_n;
        ap_wdata_d = cmd_wdata;
      end
    end

    dp_vld_d   = dp_vld_q;
    dp_write_d = dp_write_q;
    dp_size_d  = dp_size_q;
    dp_lane_d  = dp_lane_q;
    dp_wdata_d = dp_wdata_q;
    if (HREADY) begin
      dp_vld_d   = ap_vld_q;
      dp_write_d = ap_write_q;
      dp_size_d  = ap_size_q;
      dp_lane_d  = ap_addr_q[1:0];
      dp_wdata_d = ap_wdata_q;
    end

    rsp_valid_d = dp_vld_q & HREADY;
    rsp_err_d   = rsp_valid_d & HRESP;
    rsp_rdata_d = (rsp_valid_d & ~dp_write_q) ? rd_lane : 32'h0;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ap_vld_q    <= 1'b0;
      ap_addr_q   <= '0;
      ap_write_q  <= 1'b0;
      ap_size_q   <= 3'd0;
      ap_wdata_q  <= 32'h0;
      dp_vld_q    <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_size_q   <= 3'd0;
      dp_lane_q   <= 2'd0;
      dp_wdata_q  <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      ap_vld_q    <= ap_vld_d;
      ap_addr_q   <= ap_addr_d;
      ap_write_q  <= ap_write_d;
      ap_size_q   <= ap_size_d;
      ap_wdata_q  <= ap_wdata_d;
      dp_vld_q    <= dp_vld_d;
      dp_write_q  <= dp_write_d;
      dp_size_q   <= dp_size_d;
      dp_lane_q   <= dp_lane_d;
      dp_wdata_q  <= dp_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  ahbl_lane_align u_align (
    .size   (dp_size_q),
    .lane   (dp_lane_q),
    .wdata  (dp_wdata_q),
    .hrdata (HRDATA),
    .hwdata (HWDATA),
    .rdata  (rd_lane)
  );

  assign HADDR     = ap_addr_q;
  assign HTRANS    = ap_vld_q ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HWRITE    = ap_write_q;
  assign HSIZE     = ap_size_q;
  assign busy      = ap_vld_q | dp_vld_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ahbl_cmd_master.sv
// Bench for ahbl_cmd_master: vector table, hand-built wait/error/reset
// sequences, and a random run against a memory-backed reference model.
module tb_ahbl_cmd_master;
  import ahbl_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size;
  logic        rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE;

  ahbl_cmd_master #(.ADDR_W(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive_cmd(input logic v, input logic wr, input logic [2:0] sz,
                           input logic [31:0] a, input logic [31:0] d);
    cmd_valid = v; cmd_write = wr; cmd_size = sz; cmd_addr = a; cmd_wdata = d;
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] addr, wdata, hrdata, e_haddr;
    logic [2:0]  e_hsize;
    logic [31:0] e_hwdata, e_rdata;
  } vec_t;
  vec_t vt[9];

  task automatic run_vec(input int i);
    vec_t v = vt[i];
    drive_cmd(1'b1, v.wr, v.sz, v.addr, v.wdata);
    HRDATA = v.hrdata; HREADY = 1'b1; HRESP = 1'b0;
    #1 chk($sformatf("v%0d_cmd_ready", i), 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk($sformatf("v%0d_htrans", i), 32'(HTRANS), 32'(HTRANS_NONSEQ));
    chk($sformatf("v%0d_haddr", i), HADDR, v.e_haddr);
    chk($sformatf("v%0d_hsize", i), 32'(HSIZE), 32'(v.e_hsize));
    chk($sformatf("v%0d_hwrite", i), 32'(HWRITE), 32'(v.wr));
    chk($sformatf("v%0d_rsp_early", i), 32'(rsp_valid), 32'd0);
    tick();
    chk($sformatf("v%0d_htrans_idle", i), 32'(HTRANS), 32'(HTRANS_IDLE));
    if (v.wr) chk($sformatf("v%0d_hwdata", i), HWDATA, v.e_hwdata);
    chk($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
    tick();
    chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
    chk($sformatf("v%0d_rsp_err", i), 32'(rsp_err), 32'd0);
    chk($sformatf("v%0d_rsp_rdata", i), rsp_rdata, v.e_rdata);
    tick();
    chk($sformatf("v%0d_rsp_pulse", i), 32'(rsp_valid), 32'd0);
    chk($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
  endtask

  // Random-run reference: commands in order, applied to a plain byte-level memory.
  typedef struct { logic wr; logic [2:0] sz; logic [31:0] addr, wdata; } cmd_t;
  cmd_t        q[$];
  logic [31:0] rmem[16];
  logic [31:0] smem[16];
  logic        s_act, s_wr;
  logic [31:0] s_addr;
  logic [2:0]  s_size;

  function automatic logic [31:0] ref_apply(input cmd_t c);
    int nb, base, lane, idx;
    logic [31:0] r;
    nb   = (c.sz > 3'd2) ? 4 : (1 << c.sz);
    base = int'(c.addr) & ~(nb - 1);
    lane = base % 4;
    idx  = (base / 4) % 16;
    r    = 32'h0;
    for (int b = 0; b < nb; b++) begin
      if (c.wr) begin
        rmem[idx] = (rmem[idx] & ~(32'hFF << (8 * (lane + b))))
                  | (((c.wdata >> (8 * b)) & 32'hFF) << (8 * (lane + b)));
      end else begin
        r = r | (((rmem[idx] >> (8 * (lane + b))) & 32'hFF) << (8 * b));
      end
    end
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cmd_t c;
    logic acc;
    int   sz_eff;

    vt[0] = '{1'b1, 3'd2, 32'h2000_0004, 32'hDEAD_BEEF, 32'h0, 32'h2000_0004, 3'd2, 32'hDEAD_BEEF, 32'h0};
    vt[1] = '{1'b0, 3'd0, 32'h2000_0003, 32'h0, 32'hAABB_CCDD, 32'h2000_0003, 3'd0, 32'h0, 32'h0000_00AA};
    vt[2] = '{1'b1, 3'd1, 32'h2000_0002, 32'h0000_1234, 32'h0, 32'h2000_0002, 3'd1, 32'h1234_1234, 32'h0};
    vt[3] = '{1'b1, 3'd1, 32'h2000_0003, 32'hABCD_5678, 32'h0, 32'h2000_0002, 3'd1, 32'h5678_5678, 32'h0};
    vt[4] = '{1'b0, 3'd1, 32'h2000_0002, 32'h0, 32'hAABB_CCDD, 32'h2000_0002, 3'd1, 32'h0, 32'h0000_AABB};
    vt[5] = '{1'b0, 3'd2, 32'h2000_0007, 32'h0, 32'h1357_9BDF, 32'h2000_0004, 3'd2, 32'h0, 32'h1357_9BDF};
    vt[6] = '{1'b1, 3'd7, 32'h0000_1001, 32'hCAFE_F00D, 32'h0, 32'h0000_1000, 3'd2, 32'hCAFE_F00D, 32'h0};
    vt[7] = '{1'b1, 3'd0, 32'h0000_0001, 32'h1234_56EF, 32'h0, 32'h0000_0001, 3'd0, 32'hEFEF_EFEF, 32'h0};
    vt[8] = '{1'b0, 3'd0, 32'h0000_0001, 32'h0, 32'h1122_3344, 32'h0000_0001, 3'd0, 32'h0, 32'h0000_0033};

    HRESETn = 1'b0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
    drive_cmd(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    #2;
    chk("rst_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hwrite", 32'(HWRITE), 32'd0);
    chk("rst_hsize", 32'(HSIZE), 32'd0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    #10 HRESETn = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) run_vec(i);

    // Four back-to-back word reads; slave returns 0x11..0x44.
    for (int cy = 0; cy < 7; cy++) begin
      drive_cmd(cy < 4, 1'b0, 3'd2, 32'h2000_0100 + 32'(cy * 4), 32'h0);
      HRDATA = (cy >= 2) ? 32'(32'h11 * (cy - 1)) : 32'h0;
      #1 if (cy < 4) chk($sformatf("b2b_ready%0d", cy), 32'(cmd_ready), 32'd1);
      tick();
      chk($sformatf("b2b_htrans%0d", cy), 32'(HTRANS), (cy < 4) ? 32'(HTRANS_NONSEQ) : 32'(HTRANS_IDLE));
      chk($sformatf("b2b_rsp%0d", cy), 32'(rsp_valid), 32'(cy >= 2 && cy < 6));
      if (cy >= 2 && cy < 6) chk($sformatf("b2b_rdata%0d", cy), rsp_rdata, 32'(32'h11 * (cy - 1)));
    end
    cmd_valid = 1'b0;

    // Three wait states on a write data phase with a read queued behind it.
    drive_cmd(1'b1, 1'b1, 3'd2, 32'h2000_0010, 32'h0102_0304); HREADY = 1'b1;
    tick();
    drive_cmd(1'b1, 1'b0, 3'd2, 32'h2000_0020, 32'h0);
    tick();
    drive_cmd(1'b1, 1'b1, 3'd0, 32'h2000_0031, 32'h0000_005A);
    HREADY = 1'b0; HRDATA = 32'h0;
    for (int w = 0; w < 3; w++) begin
      #1 chk("wait_cmd_ready", 32'(cmd_ready), 32'd0);
      tick();
      chk("wait_htrans", 32'(HTRANS), 32'(HTRANS_NONSEQ));
      chk("wait_haddr", HADDR, 32'h2000_0020);
      chk("wait_hwdata", HWDATA, 32'h0102_0304);
      chk("wait_rsp", 32'(rsp_valid), 32'd0);
    end
    HREADY = 1'b1;
    #1 chk("wait_release_ready", 32'(cmd_ready), 32'd1);
    tick();
    chk("wait_rsp1_valid", 32'(rsp_valid), 32'd1);
    chk("wait_rsp1_err", 32'(rsp_err), 32'd0);
    chk("wait_haddr3", HADDR, 32'h2000_0031);
    cmd_valid = 1'b0; HRDATA = 32'h7766_5544;
    tick();
    chk("wait_rsp2_valid", 32'(rsp_valid), 32'd1);
    chk("wait_rsp2_rdata", rsp_rdata, 32'h7766_5544);
    chk("wait_hwdata3", HWDATA, 32'h5A5A_5A5A);
    tick();
    chk("wait_rsp3_valid", 32'(rsp_valid), 32'd1);
    tick();
    chk("wait_drained", 32'(busy), 32'd0);

    // Two-cycle error response on a read, write queued behind it.
    drive_cmd(1'b1, 1'b0, 3'd2, 32'h2000_0040, 32'h0);
    tick();
    drive_cmd(1'b1, 1'b1, 3'd2, 32'h2000_0044, 32'hFEED_FACE);
    tick();
    cmd_valid = 1'b0; HREADY = 1'b0; HRESP = 1'b1;
    tick();
    chk("err1_rsp", 32'(rsp_valid), 32'd0);
    chk("err1_htrans", 32'(HTRANS), 32'(HTRANS_NONSEQ));
    chk("err1_haddr", HADDR, 32'h2000_0044);
    HREADY = 1'b1;
    tick();
    chk("err2_rsp", 32'(rsp_valid), 32'd1);
    chk("err2_err", 32'(rsp_err), 32'd1);
    HRESP = 1'b0;
    tick();
    chk("err_next_rsp", 32'(rsp_valid), 32'd1);
    chk("err_next_err", 32'(rsp_err), 32'd0);
    tick();
    chk("err_single_rsp", 32'(rsp_valid), 32'd0);
    chk("err_idle", 32'(busy), 32'd0);

    // Reset in the middle of a waited read.
    drive_cmd(1'b1, 1'b0, 3'd2, 32'h2000_0050, 32'h0);
    tick();
    cmd_valid = 1'b0;
    tick();
    HREADY = 1'b0;
    tick();
    HRESETn = 1'b0;
    #1;
    chk("mrst_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_haddr", HADDR, 32'h0);
    chk("mrst_hwdata", HWDATA, 32'h0);
    #3 HRESETn = 1'b1; HREADY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mrst_no_rsp", 32'(rsp_valid), 32'd0);
      chk("mrst_no_trans", 32'(HTRANS), 32'(HTRANS_IDLE));
    end
    run_vec(0);

    // Random traffic with a memory-backed slave and random wait states.
    for (int i = 0; i < 16; i++) begin
      rmem[i] = $urandom;
      smem[i] = rmem[i];
    end
    s_act = 1'b0; s_wr = 1'b0; s_addr = 32'h0; s_size = 3'd0;
    acc = 1'b1; cmd_valid = 1'b0;
    for (int cyc = 0; cyc < 460; cyc++) begin
      if (rsp_valid) begin
        if (q.size() == 0) chk("rnd_unexpected_rsp", 32'd1, 32'd0);
        else begin
          c = q.pop_front();
          chk("rnd_rdata", rsp_rdata, ref_apply(c));
          chk("rnd_err", 32'(rsp_err), 32'd0);
        end
      end
      chk("rnd_busy", 32'(busy), 32'(q.size() != 0));
      chk("rnd_outstanding", 32'(q.size() <= 2), 32'd1);
      if (cyc >= 400 && q.size() == 0 && (!cmd_valid || acc)) break;
      if (!cmd_valid || acc) begin
        drive_cmd((cyc < 400) && ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 32'h2000_0000 + 32'($urandom_range(0, 63)), $urandom);
      end
      HREADY = s_act ? ($urandom_range(0, 3) != 0) : 1'b1;
      HRDATA = (s_act && !s_wr) ? smem[s_addr[5:2]] : $urandom;
      #1;
      acc = cmd_valid & cmd_ready;
      if (acc) q.push_back('{cmd_write, cmd_size, cmd_addr, cmd_wdata});
      if (HREADY) begin
        if (s_act && s_wr) begin
          sz_eff = (s_size > 3'd2) ? 2 : int'(s_size);
          for (int b = 0; b < (1 << sz_eff); b++)
            if (int'(s_addr[1:0]) + b < 4)
              smem[s_addr[5:2]][8 * (int'(s_addr[1:0]) + b) +: 8] = HWDATA[8 * (int'(s_addr[1:0]) + b) +: 8];
        end
        s_act = (HTRANS == HTRANS_NONSEQ);
        s_wr = HWRITE; s_addr = HADDR; s_size = HSIZE;
      end
      @(posedge HCLK);
      #1;
    end
    chk("rnd_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
